// File: rtl/fwd_hazard_pkg.sv
// Shared constants for the EX-stage forwarding and load-use hazard logic.
// Select codes drive the 3:1 operand muxes in front of the ALU.
package fwd_hazard_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_MEMWB   = 2'b01;
  localparam logic [1:0] FWD_EXMEM   = 2'b10;

  function automatic logic src_hit(
    input logic       use_s,
    input logic [7:0] rs,
    input logic       v,
    input logic       rw,
    input logic [7:0] rd
  );
    return use_s && (rs != 8'd0) && v && rw && (rd == rs);
  endfunction

endpackage

// File: rtl/fwd_src_resolve.sv
// Per-operand producer match against the EX and MEM tracker entries.
// The youngest producer (EX) wins over the older one (MEM).
module fwd_src_resolve
  import fwd_hazard_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic          i_use,
  input  logic [AW-1:0] i_rs,
  input  logic          i_ex_v,
  input  logic          i_ex_rw,
  input  logic [AW-1:0] i_ex_rd,
  input  logic          i_mem_v,
  input  logic          i_mem_rw,
  input  logic [AW-1:0] i_mem_rd,
  output logic [1:0]    o_sel,
  output logic          o_ex_hit
);

  logic [7:0] w_rs;
  logic [7:0] w_ex_rd;
  logic [7:0] w_mem_rd;
  logic       w_ex_hit;
  logic       w_mem_hit;
  logic       w_mem_only;

  always_comb begin
    w_rs     = 8'd0;
    w_ex_rd  = 8'd0;
    w_mem_rd = 8'd0;
    w_rs[AW-1:0]     = i_rs;
    w_ex_rd[AW-1:0]  = i_ex_rd;
    w_mem_rd[AW-1:0] = i_mem_rd;
  end

  assign w_ex_hit  = src_hit(i_use, w_rs, i_ex_v, i_ex_rw, w_ex_rd);
  assign w_mem_hit = src_hit(i_use, w_rs, i_mem_v, i_mem_rw, w_mem_rd);
  assign w_mem_only = w_mem_hit && !w_ex_hit;

  always_comb begin
    o_sel = FWD_REGFILE;
    unique case (1'b1)
      w_ex_hit:   o_sel = FWD_EXMEM;
      w_mem_only: o_sel = FWD_MEMWB;
      default:    o_sel = FWD_REGFILE;
    endcase
  end

  assign o_ex_hit = w_ex_hit;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use stall control for the 5-stage pipeline.
// Tracks EX/MEM destinations and registers the selects for the EX cycle.
module fwd_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              ex_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              idex_bubble,
  output logic [CNT_W-1:0]  stall_count
);

  import fwd_hazard_pkg::*;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              r_ex_v;
  logic              r_ex_rw;
  logic              r_ex_mr;
  logic [REG_AW-1:0] r_ex_rd;
  logic              r_mem_v;
  logic              r_mem_rw;
  logic [REG_AW-1:0] r_mem_rd;
  logic [1:0]        r_fwd_a;
  logic [1:0]        r_fwd_b;
  logic [CNT_W-1:0]  r_stall_count;

  logic [1:0] w_sel_a;
  logic [1:0] w_sel_b;
  logic       w_ex_hit_a;
  logic       w_ex_hit_b;
  logic       w_load_use;
  logic       w_advance;
  logic       w_bubble_ex;

  fwd_src_resolve #(.AW(REG_AW)) u_res_a (
    .i_use    (id_use_rs1),
    .i_rs     (id_rs1),
    .i_ex_v   (r_ex_v),
    .i_ex_rw  (r_ex_rw),
    .i_ex_rd  (r_ex_rd),
    .i_mem_v  (r_mem_v),
    .i_mem_rw (r_mem_rw),
    .i_mem_rd (r_mem_rd),
    .o_sel    (w_sel_a),
    .o_ex_hit (w_ex_hit_a)
  );

  fwd_src_resolve #(.AW(REG_AW)) u_res_b (
    .i_use    (id_use_rs2),
    .i_rs     (id_rs2),
    .i_ex_v   (r_ex_v),
    .i_ex_rw  (r_ex_rw),
    .i_ex_rd  (r_ex_rd),
    .i_mem_v  (r_mem_v),
    .i_mem_rw (r_mem_rw),
    .i_mem_rd (r_mem_rd),
    .o_sel    (w_sel_b),
    .o_ex_hit (w_ex_hit_b)
  );

  // A flush kills the consumer, so it must never also stall it.
  assign w_load_use = id_valid && !ex_flush && r_ex_v && r_ex_mr
                   && (w_ex_hit_a || w_ex_hit_b);

  assign w_advance   = id_valid && !w_load_use && !ex_flush;
  assign w_bubble_ex = !w_advance;

  assign pc_write    = !w_load_use;
  assign ifid_write  = !w_load_use;
  assign idex_bubble = w_load_use || ex_flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex_v   <= 1'b0;
      r_ex_rw  <= 1'b0;
      r_ex_mr  <= 1'b0;
      r_ex_rd  <= '0;
      r_mem_v  <= 1'b0;
      r_mem_rw <= 1'b0;
      r_mem_rd <= '0;
    end else begin
      r_mem_v  <= r_ex_v;
      r_mem_rw <= r_ex_rw;
      r_mem_rd <= r_ex_rd;
      r_ex_v   <= w_advance;
      if (w_advance) begin
        r_ex_rw <= id_reg_write;
        r_ex_mr <= id_mem_read;
        r_ex_rd <= id_rd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fwd_a <= FWD_REGFILE;
      r_fwd_b <= FWD_REGFILE;
    end else if (w_bubble_ex) begin
      r_fwd_a <= FWD_REGFILE;
      r_fwd_b <= FWD_REGFILE;
    end else begin
      r_fwd_a <= w_sel_a;
      r_fwd_b <= w_sel_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_count <= '0;
    end else if (w_load_use && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + CNT_ONE;
    end
  end

  assign fwd_a       = r_fwd_a;
  assign fwd_b       = r_fwd_b;
  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed pipeline scenarios followed by random instruction streams,
// compared against an in-flight-producer queue model of the pipeline.
module tb_fwd_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic [4:0]  id_rd;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        ex_flush;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic        pc_write;
  logic        ifid_write;
  logic        idex_bubble;
  logic [31:0] stall_count;
  logic [1:0]  s_fwd_a;
  logic [1:0]  s_fwd_b;
  logic        s_pc_write;
  logic        s_ifid_write;
  logic        s_idex_bubble;
  logic [1:0]  s_stall_count;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .ex_flush(ex_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .pc_write(pc_write),
    .ifid_write(ifid_write), .idex_bubble(idex_bubble),
    .stall_count(stall_count)
  );

  // Narrow counter copy exercises saturation within a short run.
  fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .ex_flush(ex_flush),
    .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .pc_write(s_pc_write),
    .ifid_write(s_ifid_write), .idex_bubble(s_idex_bubble),
    .stall_count(s_stall_count)
  );

  typedef struct {
    bit v;
    int rd;
    bit rw;
    bit mr;
  } ent_t;

  ent_t pipe[$];
  int   m_fa;
  int   m_fb;
  int   m_cnt;
  int   m_cnt2;
  bit   m_lu;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Age of the youngest in-flight writer of rs: 0 = in EX, 1 = in MEM.
  function automatic int producer_age(int rs, bit use_s);
    if (!use_s || rs == 0) return -1;
    for (int i = 0; i < pipe.size(); i++)
      if (pipe[i].v && pipe[i].rw && pipe[i].rd == rs) return i;
    return -1;
  endfunction

  function automatic int sel_of(int age);
    if (age == 0) return 2;
    if (age == 1) return 1;
    return 0;
  endfunction

  task automatic step(bit v, int rs1, int rs2, bit u1, bit u2,
                      int rd, bit rw, bit mr, bit fl, bit rst, bit ck);
    int   a1;
    int   a2;
    bit   lu;
    ent_t e;
    id_valid     = v;
    id_rs1       = rs1[4:0];
    id_rs2       = rs2[4:0];
    id_use_rs1   = u1;
    id_use_rs2   = u2;
    id_rd        = rd[4:0];
    id_reg_write = rw;
    id_mem_read  = mr;
    ex_flush     = fl;
    reset        = rst;
    a1 = producer_age(rs1, u1);
    a2 = producer_age(rs2, u2);
    lu = v && !fl && pipe[0].mr && (a1 == 0 || a2 == 0);
    m_lu = lu;
    @(negedge clk);
    if (ck) begin
      chk("pc_write", pc_write, !lu);
      chk("ifid_write", ifid_write, !lu);
      chk("idex_bubble", idex_bubble, lu || fl);
      chk("fwd_a", fwd_a, m_fa);
      chk("fwd_b", fwd_b, m_fb);
      chk("stall_count", stall_count, m_cnt);
      chk("stall_count_sat", s_stall_count, m_cnt2);
    end
    @(posedge clk);
    if (rst) begin
      e = '{0, 0, 0, 0};
      pipe = '{e, e};
      m_fa = 0;
      m_fb = 0;
      m_cnt = 0;
      m_cnt2 = 0;
    end else begin
      if (lu) begin
        m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      if (lu || fl || !v) begin
        m_fa = 0;
        m_fb = 0;
        e = '{0, 0, 0, 0};
      end else begin
        m_fa = sel_of(a1);
        m_fb = sel_of(a2);
        e = '{1, rd, rw, mr};
      end
      pipe.push_front(e);
      pipe = pipe[0:1];
    end
    #1;
  endtask

  task automatic alu(int rd, int rs1, int rs2, bit fl = 0, bit rst = 0);
    step(1, rs1, rs2, 1, 1, rd, 1, 0, fl, rst, 1);
  endtask

  task automatic ld(int rd, int rs1);
    step(1, rs1, 0, 1, 0, rd, 1, 1, 0, 0, 1);
  endtask

  task automatic nop();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    bit   hold;
    bit   v;
    bit   u1;
    bit   u2;
    bit   rw;
    bit   mr;
    bit   fl;
    bit   rst;
    int   rs1;
    int   rs2;
    int   rd;
    ent_t e0;
    e0 = '{0, 0, 0, 0};
    pipe = '{e0, e0};
    m_fa = 0;
    m_fb = 0;
    m_cnt = 0;
    m_cnt2 = 0;
    #1;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("rst_fwd_a", fwd_a, 2'b00);
    chk("rst_count", stall_count, 0);

    alu(5, 1, 2);
    alu(6, 5, 3);
    chk("exmem_fwd_a", fwd_a, 2'b10);
    chk("exmem_fwd_b", fwd_b, 2'b00);

    nop();
    alu(5, 1, 2);
    nop();
    alu(7, 4, 5);
    chk("memwb_fwd_b", fwd_b, 2'b01);
    chk("memwb_fwd_a", fwd_a, 2'b00);

    nop();
    alu(5, 1, 2);
    alu(5, 3, 4);
    alu(8, 5, 5);
    chk("youngest_a", fwd_a, 2'b10);
    chk("youngest_b", fwd_b, 2'b10);

    nop();
    nop();
    ld(5, 1);
    alu(6, 5, 1);
    chk("lu_bubble_a", fwd_a, 2'b00);
    chk("lu_count", stall_count, 1);
    chk("lu_replay_pc", pc_write, 1'b1);
    alu(6, 5, 1);
    chk("lu_after_a", fwd_a, 2'b01);

    nop();
    nop();
    alu(0, 1, 2);
    alu(6, 0, 0);
    chk("x0_a", fwd_a, 2'b00);
    chk("x0_b", fwd_b, 2'b00);

    nop();
    ld(5, 1);
    alu(6, 5, 1, 1);
    chk("flush_a", fwd_a, 2'b00);
    chk("flush_count", stall_count, 1);

    nop();
    ld(5, 1);
    alu(6, 5, 1, 0, 1);
    chk("rst_mid_count", stall_count, 0);
    chk("rst_mid_a", fwd_a, 2'b00);
    alu(6, 5, 1);

    hold = 0;
    {v, u1, u2, rw, mr} = '0;
    {rs1, rs2, rd} = '0;
    for (int i = 0; i < 600; i++) begin
      if (!hold) begin
        v   = ($urandom % 100) < 85;
        rs1 = $urandom % 6;
        rs2 = $urandom % 6;
        rd  = $urandom % 6;
        u1  = ($urandom % 100) < 85;
        u2  = ($urandom % 100) < 60;
        rw  = ($urandom % 100) < 80;
        mr  = ($urandom % 100) < 35;
      end
      fl  = ($urandom % 12) == 0;
      rst = ($urandom % 150) == 0;
      step(v, rs1, rs2, u1, u2, rd, rw, mr, fl, rst, 1);
      hold = m_lu && !rst;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
